// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the uplink frame arbiter: FSM states, grant
// encodings and the default header / idle word values.
package bus_ctrl_pkg;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_DATA = 2'b01;
  localparam logic [1:0] GRANT_STAT = 2'b10;

  localparam logic [DATA_W-1:0] HDR_DATA_DEF  = 10'h155;
  localparam logic [DATA_W-1:0] HDR_STAT_DEF  = 10'h2AA;
  localparam logic [DATA_W-1:0] IDLE_WORD_DEF = 10'h0FA;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Bit 0 is the data channel, bit 1 the
// status channel. The pointer remembers which side wins the next tie and
// only moves when a grant is actually issued.
module rr_arbiter2
  import bus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic stat_first;

  // Pick a winner: a lone requester always wins, a tie goes to the pointer
  always_comb begin
    gnt = GRANT_NONE;
    if (en) begin
      if (req[1] && (stat_first || !req[0])) begin
        gnt = GRANT_STAT;
      end else if (req[0]) begin
        gnt = GRANT_DATA;
      end
    end
  end

  // Pointer favours whichever channel did not win the last grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_first <= 1'b1;
    end else if (gnt != GRANT_NONE) begin
      stat_first <= gnt[0];
    end
  end

endmodule

// File: rtl/ul_frame_arbiter.sv
// Uplink frame arbiter: merges a data and a status word stream into framed
// uplink traffic. Each frame is a header word followed by the granted
// channel's words, ends on Last or after MAX_WORDS words, and is followed by
// GAP_CYCLES idle cycles. Losing the link aborts the frame in progress.
module ul_frame_arbiter
  import bus_ctrl_pkg::*;
#(
  parameter int                MAX_WORDS  = 256,
  parameter int                GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0] HDR_DATA   = HDR_DATA_DEF,
  parameter logic [DATA_W-1:0] HDR_STAT   = HDR_STAT_DEF,
  parameter logic [DATA_W-1:0] IDLE_WORD  = IDLE_WORD_DEF
) (
  input  logic              Clk10MHz,
  input  logic              nRst,
  input  logic              LinkUp,
  input  logic              DataReq,
  input  logic [DATA_W-1:0] DataWord,
  input  logic              DataLast,
  output logic              DataAck,
  input  logic              StatReq,
  input  logic [DATA_W-1:0] StatWord,
  input  logic              StatLast,
  output logic              StatAck,
  output logic [DATA_W-1:0] outData,
  output logic              outDataEn,
  output logic [1:0]        Grant,
  output logic              AbortPulse,
  output logic              TruncPulse
);

  localparam int               GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  // Word counter saturates instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state, state_n;
  logic [1:0]          grant, grant_n;
  logic [1:0]          arb_gnt;
  logic [1:0]          req_vec;
  logic                arb_en;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
  logic                g_req, g_last;
  logic [DATA_W-1:0]   g_word;
  logic                xfer_ack, at_limit;
  logic [DATA_W-1:0]   out_data_n;
  logic                out_en_n, trunc_n, abort_n;

  assign req_vec = {StatReq, DataReq};
  assign arb_en  = (state == S_IDLE) && LinkUp;
  assign Grant   = grant;

  rr_arbiter2 u_rr (
    .clk   (Clk10MHz),
    .rst_n (nRst),
    .en    (arb_en),
    .req   (req_vec),
    .gnt   (arb_gnt)
  );

  // Route the granted channel's show-ahead word to the framer
  always_comb begin
    g_req  = 1'b0;
    g_word = DataWord;
    g_last = 1'b0;
    case (grant)
      GRANT_DATA: begin
        g_req  = DataReq;
        g_word = DataWord;
        g_last = DataLast;
      end
      GRANT_STAT: begin
        g_req  = StatReq;
        g_word = StatWord;
        g_last = StatLast;
      end
      default: ;
    endcase
  end

  // The MAX_WORDS-th word is being offered when the count sits one below it
  assign at_limit = (cnt == CNT_LAST);
  assign xfer_ack = (state == S_XFER) && LinkUp && g_req;

  // FSM state register
  always_ff @(posedge Clk10MHz or negedge nRst) begin
    if (!nRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (arb_gnt != GRANT_NONE) state_n = S_HDR;
      S_HDR:  state_n = LinkUp ? S_XFER : S_IDLE;
      S_XFER: begin
        if (!LinkUp) begin
          state_n = S_IDLE;
        end else if (xfer_ack && (g_last || at_limit)) begin
          state_n = S_GAP;
        end
      end
      S_GAP:  if (gap_cnt == GAP_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: combinational acks plus next values for the registered outputs
  always_comb begin
    DataAck    = xfer_ack && (grant == GRANT_DATA);
    StatAck    = xfer_ack && (grant == GRANT_STAT);
    out_en_n   = 1'b0;
    out_data_n = IDLE_WORD;
    trunc_n    = 1'b0;
    abort_n    = 1'b0;
    cnt_n      = cnt;
    grant_n    = grant;
    gap_cnt_n  = '0;
    case (state)
      S_IDLE: begin
        if (arb_gnt != GRANT_NONE) begin
          grant_n = arb_gnt;
          cnt_n   = '0;
        end
      end
      S_HDR: begin
        if (LinkUp) begin
          out_en_n   = 1'b1;
          out_data_n = (grant == GRANT_STAT) ? HDR_STAT : HDR_DATA;
        end else begin
          abort_n = 1'b1;
          grant_n = GRANT_NONE;
        end
      end
      S_XFER: begin
        if (!LinkUp) begin
          abort_n = 1'b1;
          grant_n = GRANT_NONE;
        end else if (xfer_ack) begin
          out_en_n   = 1'b1;
          out_data_n = g_word;
          cnt_n      = sat_inc(cnt);
          trunc_n    = at_limit && !g_last;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          grant_n = GRANT_NONE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered output word, event pulses, grant and counters
  always_ff @(posedge Clk10MHz or negedge nRst) begin
    if (!nRst) begin
      outData    <= IDLE_WORD;
      outDataEn  <= 1'b0;
      AbortPulse <= 1'b0;
      TruncPulse <= 1'b0;
      grant      <= GRANT_NONE;
      cnt        <= '0;
      gap_cnt    <= '0;
    end else begin
      outData    <= out_data_n;
      outDataEn  <= out_en_n;
      AbortPulse <= abort_n;
      TruncPulse <= trunc_n;
      grant      <= grant_n;
      cnt        <= cnt_n;
      gap_cnt    <= gap_cnt_n;
    end
  end

endmodule

// File: tb/tb_ul_frame_arbiter.sv
// Self-checking bench for ul_frame_arbiter: directed scenarios plus a
// randomized run, checked against a per-channel frame model.
module tb_ul_frame_arbiter;

  localparam logic [9:0] HDR_D  = 10'h155;
  localparam logic [9:0] HDR_S  = 10'h2AA;
  localparam logic [9:0] IDLE_W = 10'h0FA;
  localparam int         MAXW   = 256;

  logic       clk = 1'b0;
  logic       nrst, link_up;
  logic       data_req, data_last, stat_req, stat_last;
  logic [9:0] data_word, stat_word;
  logic       data_ack, stat_ack;
  logic [9:0] out_data;
  logic       out_en;
  logic [1:0] grant;
  logic       abort_p, trunc_p;

  ul_frame_arbiter dut (
    .Clk10MHz   (clk),
    .nRst       (nrst),
    .LinkUp     (link_up),
    .DataReq    (data_req),
    .DataWord   (data_word),
    .DataLast   (data_last),
    .DataAck    (data_ack),
    .StatReq    (stat_req),
    .StatWord   (stat_word),
    .StatLast   (stat_last),
    .StatAck    (stat_ack),
    .outData    (out_data),
    .outDataEn  (out_en),
    .Grant      (grant),
    .AbortPulse (abort_p),
    .TruncPulse (trunc_p)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic       en;
    logic [9:0] d;
    logic [1:0] g;
    logic       tr;
    logic       ab;
    logic       dack;
    logic       sack;
  } samp_t;

  samp_t      trace[$];
  logic [9:0] src_w[2][$];
  bit         src_l[2][$];
  bit         stall[2];
  bit         rand_stall;
  int         acked[2];
  logic [9:0] exp_tok[2][$];
  logic [9:0] obs_tok[2][$];
  int         mdl_cnt[2];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: a channel's output is a header then its words; a frame
  // closes on Last or once MAXW words have gone out, the next word reopens.
  function automatic logic [9:0] hdr_of(input int c);
    return (c == 0) ? HDR_D : HDR_S;
  endfunction

  task automatic mdl_push(input int c, input logic [9:0] w, input bit l);
    if (mdl_cnt[c] == 0) exp_tok[c].push_back(hdr_of(c));
    exp_tok[c].push_back(w);
    mdl_cnt[c]++;
    if (l || mdl_cnt[c] == MAXW) mdl_cnt[c] = 0;
  endtask

  task automatic src_push(input int c, input logic [9:0] w, input bit l);
    src_w[c].push_back(w);
    src_l[c].push_back(l);
  endtask

  task automatic add_word(input int c, input logic [9:0] w, input bit l);
    src_push(c, w, l);
    mdl_push(c, w, l);
  endtask

  // One clock: drive at negedge, check acks, sample outputs after posedge
  task automatic tick();
    samp_t s;
    logic  dk, sk;
    for (int c = 0; c < 2; c++) if (rand_stall) stall[c] = ($urandom_range(0, 3) == 0);
    data_req  = (src_w[0].size() > 0) && !stall[0];
    data_word = (src_w[0].size() > 0) ? src_w[0][0] : 10'h000;
    data_last = (src_w[0].size() > 0) ? src_l[0][0] : 1'b0;
    stat_req  = (src_w[1].size() > 0) && !stall[1];
    stat_word = (src_w[1].size() > 0) ? src_w[1][0] : 10'h000;
    stat_last = (src_w[1].size() > 0) ? src_l[1][0] : 1'b0;
    #5;
    dk = data_ack;
    sk = stat_ack;
    chk("data_ack_legal", {31'd0, data_ack & ~((grant == 2'b01) & link_up & data_req)}, 32'd0);
    chk("stat_ack_legal", {31'd0, stat_ack & ~((grant == 2'b10) & link_up & stat_req)}, 32'd0);
    @(posedge clk);
    #1;
    if (dk) begin
      void'(src_w[0].pop_front());
      void'(src_l[0].pop_front());
      acked[0]++;
    end
    if (sk) begin
      void'(src_w[1].pop_front());
      void'(src_l[1].pop_front());
      acked[1]++;
    end
    s.en = out_en; s.d = out_data; s.g = grant; s.tr = trunc_p; s.ab = abort_p;
    s.dack = dk; s.sack = sk;
    trace.push_back(s);
    if (!out_en) chk("idle_word", out_data, IDLE_W);
    else if (grant == 2'b01) obs_tok[0].push_back(out_data);
    else if (grant == 2'b10) obs_tok[1].push_back(out_data);
    else chk("grant_with_output", grant, 2'b01);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_w[0].size() > 0 || src_w[1].size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_budget", src_w[0].size() + src_w[1].size(), 0);
    repeat (10) tick();
  endtask

  task automatic wait_acked(input int c, input int n, input string tag);
    int k = 0;
    while (acked[c] < n && k < 40) begin
      tick();
      k++;
    end
    chk(tag, acked[c], n);
  endtask

  task automatic compare_sb(input string tag);
    string nm;
    for (int c = 0; c < 2; c++) begin
      nm = (c == 0) ? "_data" : "_stat";
      chk({tag, "_len", nm}, obs_tok[c].size(), exp_tok[c].size());
      for (int i = 0; i < obs_tok[c].size() && i < exp_tok[c].size(); i++) begin
        chk({tag, "_word", nm}, obs_tok[c][i], exp_tok[c][i]);
        if (obs_tok[c][i] !== exp_tok[c][i]) break;
      end
      obs_tok[c].delete();
      exp_tok[c].delete();
      mdl_cnt[c] = 0;
    end
  endtask

  function automatic int find_word(input logic [9:0] v);
    foreach (trace[k]) if (trace[k].en && trace[k].d == v) return k;
    return -1;
  endfunction

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, i2, i3, tc, tpos, ac, len;
    logic [9:0] hq[$];
    samp_t s;

    // Reset state with requests and link active
    nrst = 1'b0; link_up = 1'b1; rand_stall = 0; stall[0] = 0; stall[1] = 0;
    data_req = 1'b1; data_word = 10'h001; data_last = 1'b0;
    stat_req = 1'b1; stat_word = 10'h002; stat_last = 1'b0;
    acked[0] = 0; acked[1] = 0; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data, IDLE_W);
    chk("rst_out_en", out_en, 0);
    chk("rst_grant", grant, 0);
    chk("rst_data_ack", data_ack, 0);
    chk("rst_stat_ack", stat_ack, 0);
    chk("rst_abort", abort_p, 0);
    chk("rst_trunc", trunc_p, 0);
    nrst = 1'b1;

    // Round robin with both channels busy: status wins the first tie
    trace.delete();
    for (int k = 0; k < 4; k++) begin
      add_word(0, 10'(10'h300 + k), 1'b1);
      add_word(1, 10'(10'h380 + k), 1'b1);
    end
    drain(400);
    foreach (trace[k]) if (trace[k].en && (trace[k].d == HDR_D || trace[k].d == HDR_S)) hq.push_back(trace[k].d);
    chk("rr_hdr_count", hq.size(), 8);
    for (int k = 0; k < hq.size() && k < 8; k++) chk("rr_hdr_order", hq[k], (k % 2 == 0) ? HDR_S : HDR_D);
    compare_sb("rr");

    // Simple 3-word data frame: latency, framing, gap and grant release
    trace.delete();
    add_word(0, 10'h001, 1'b0);
    add_word(0, 10'h002, 1'b0);
    add_word(0, 10'h003, 1'b1);
    drain(50);
    i = -1;
    foreach (trace[k]) if (i < 0 && trace[k].en) i = k;
    chk("t2_hdr_latency", i, 1);
    if (i < 0) i = 0;
    chk("t2_hdr", {trace[i].en, trace[i].d}, {1'b1, HDR_D});
    chk("t2_w1", {trace[i+1].en, trace[i+1].d}, {1'b1, 10'h001});
    chk("t2_w2", {trace[i+2].en, trace[i+2].d}, {1'b1, 10'h002});
    chk("t2_w3", {trace[i+3].en, trace[i+3].d}, {1'b1, 10'h003});
    chk("t2_no_ack_in_hdr", trace[i].dack, 0);
    chk("t2_first_ack", trace[i+1].dack, 1);
    chk("t2_gap1", {trace[i+4].en, trace[i+4].g}, {1'b0, 2'b01});
    chk("t2_gap2", {trace[i+5].en, trace[i+5].g}, {1'b0, 2'b00});
    compare_sb("t2");

    // Underrun: data request withdrawn for 4 cycles mid-frame
    trace.delete(); acked[0] = 0;
    for (int k = 1; k <= 6; k++) add_word(0, 10'(10'h010 + k), k == 6);
    wait_acked(0, 2, "t4_reach_w2");
    stall[0] = 1;
    repeat (4) tick();
    stall[0] = 0;
    drain(100);
    i2 = find_word(10'h012);
    i3 = find_word(10'h013);
    chk("t4_resume_distance", i3 - i2, 5);
    if (i2 >= 0 && i2 + 4 < trace.size())
      for (int k = 1; k <= 4; k++) chk("t4_idle", {trace[i2+k].en, trace[i2+k].d}, {1'b0, IDLE_W});
    compare_sb("t4");

    // 300 words with no Last: truncation after 256, rest in a new frame
    trace.delete();
    for (int j = 0; j < 300; j++) add_word(0, 10'(j), 1'b0);
    drain(400);
    tc = 0; tpos = -1;
    foreach (trace[k]) if (trace[k].tr) begin tc++; tpos = k; end
    chk("t5_trunc_count", tc, 1);
    if (tpos >= 0) chk("t5_trunc_word", {trace[tpos].en, trace[tpos].d}, {1'b1, 10'h0FF});
    compare_sb("t5");
    link_up = 1'b0;
    repeat (2) tick();
    link_up = 1'b1;

    // Exactly 256 words with Last on the final one: no truncation
    trace.delete();
    for (int j = 0; j < 256; j++) add_word(0, 10'(j + 1), j == 255);
    add_word(0, 10'h3AB, 1'b1);
    drain(400);
    tc = 0;
    foreach (trace[k]) if (trace[k].tr) tc++;
    chk("t6_trunc_count", tc, 0);
    compare_sb("t6");

    // Link loss after the 2nd word aborts the frame
    trace.delete(); acked[0] = 0;
    add_word(0, 10'h021, 1'b0);
    add_word(0, 10'h022, 1'b0);
    src_push(0, 10'h023, 1'b0);
    src_push(0, 10'h024, 1'b0);
    src_push(0, 10'h025, 1'b1);
    wait_acked(0, 2, "t7_reach_w2");
    link_up = 1'b0;
    tick();
    s = trace[$];
    chk("t7_ack_on_drop", s.dack, 0);
    chk("t7_abort", s.ab, 1);
    chk("t7_en", s.en, 0);
    chk("t7_grant", s.g, 0);
    repeat (4) begin
      tick();
      s = trace[$];
      chk("t7_hold", {s.dack, s.ab, s.en}, 3'b000);
    end
    chk("t7_no_consume", acked[0], 2);
    link_up = 1'b1;
    mdl_cnt[0] = 0;
    mdl_push(0, 10'h023, 1'b0);
    mdl_push(0, 10'h024, 1'b0);
    mdl_push(0, 10'h025, 1'b1);
    drain(50);
    compare_sb("t7");

    // Asynchronous reset mid-frame
    trace.delete(); acked[0] = 0;
    for (int k = 1; k <= 5; k++) add_word(0, 10'(10'h030 + k), k == 5);
    wait_acked(0, 2, "t8_reach_w2");
    chk("t8_pre_grant", trace[$].g, 2'b01);
    data_req = 1'b1; data_word = src_w[0][0]; data_last = 1'b0;
    #20;
    nrst = 1'b0;
    #1;
    chk("t8_out_data", out_data, IDLE_W);
    chk("t8_out_en", out_en, 0);
    chk("t8_grant", grant, 0);
    chk("t8_data_ack", data_ack, 0);
    chk("t8_pulses", {abort_p, trunc_p}, 2'b00);
    @(posedge clk);
    #1;
    chk("t8_in_reset", {abort_p, out_en}, 2'b00);
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      src_w[c].delete(); src_l[c].delete();
      exp_tok[c].delete(); obs_tok[c].delete(); mdl_cnt[c] = 0;
    end
    trace.delete();
    repeat (3) tick();
    ac = 0;
    foreach (trace[k]) if (trace[k].ab) ac++;
    chk("t8_no_abort", ac, 0);

    // Randomized frames on both channels with random request stalls
    trace.delete();
    for (int c = 0; c < 2; c++)
      for (int f = 0; f < 6; f++) begin
        len = $urandom_range(1, 12);
        for (int j = 0; j < len; j++) add_word(c, 10'($urandom_range(0, 1023)), j == len - 1);
      end
    rand_stall = 1;
    drain(3000);
    rand_stall = 0; stall[0] = 0; stall[1] = 0;
    chk("rnd_final_grant", trace[$].g, 0);
    compare_sb("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ul_frame_arbiter.md
UL_FRAME_ARBITER -- requirements
Module: ul_frame_arbiter

Interface
REQ-001 Parameter MAX_WORDS, 256: maximum payload words per frame; the frame is truncated at this count.
REQ-002 Parameter GAP_CYCLES, 2: idle cycles inserted after every frame.
REQ-003 Parameter HDR_DATA, 10'h155: header word for a data-channel frame.
REQ-004 Parameter HDR_STAT, 10'h2AA: header word for a status-channel frame.
REQ-005 Parameter IDLE_WORD, 10'h0FA: value driven on outData whenever no word is valid.
REQ-006 Clk10MHz  in  1: the single clock; all logic is on its rising edge.
REQ-007 nRst  in  1: reset, asynchronous, active-low.
REQ-008 LinkUp  in  1: downhole sync-success / link-established indication.
REQ-009 DataReq  in  1: data channel has a valid word.
REQ-010 DataWord  in  10: data channel word.
REQ-011 DataLast  in  1: the data channel word is the last of its frame.
REQ-012 DataAck  out  1: the data channel word is consumed this cycle.
REQ-013 StatReq / StatWord / StatLast  in  1/10/1: status channel, same meaning as the data channel.
REQ-014 StatAck  out  1: the status channel word is consumed this cycle.
REQ-015 outData  out  10: word to the uplink serializer path.
REQ-016 outDataEn  out  1: outData is valid.
REQ-017 Grant  out  2: current owner; 00 none, 01 data, 10 status.
REQ-018 AbortPulse / TruncPulse  out  1/1: one-cycle event flags.

Function
REQ-019 The FSM SHALL have the states S_IDLE, S_HDR, S_XFER and S_GAP.
REQ-020 S_IDLE:
- while LinkUp=1 and either Req is high, the arbiter picks a winner, latches it into Grant and moves to S_HDR;
- otherwise it stays in S_IDLE.
REQ-021 Arbitration SHALL be round-robin: with both Reqs high, the channel not granted last wins; the first tie after reset goes to status.
REQ-022 S_HDR SHALL last one cycle.
- The next cycle shows outData=HDR_DATA or HDR_STAT and outDataEn=1.
- The FSM then moves to S_XFER.
- No Ack is asserted in S_HDR.
REQ-023 S_XFER:
- Ack of the granted channel = Req of the granted channel AND LinkUp (combinational).
- The ungranted Ack SHALL stay 0 at all times.
REQ-024 Latency:
- a word acked in cycle N SHALL appear on outData with outDataEn=1 in cycle N+1;
- outData and outDataEn are registered.
REQ-025 Requesters are show-ahead: Word and Last are valid while Req=1, and advance after an Ack.
REQ-026 Underrun: if the granted Req is 0 in S_XFER:
- cycle N+1 shows outData=IDLE_WORD and outDataEn=0;
- the FSM stays in S_XFER and the word count holds.
REQ-027 Word counter, 9 bits:
- cleared on entry to S_HDR;
- incremented on each Ack;
- never wraps.
REQ-028 An acked word with Last=1 SHALL move the FSM to S_GAP.
REQ-029 Truncation:
- if the count reaches MAX_WORDS without Last, the MAX_WORDS-th acked word ends the frame;
- TruncPulse=1 for one cycle;
- the FSM moves to S_GAP.
REQ-030 A word with Last=1 that is also the MAX_WORDS-th word SHALL end the frame normally, with no TruncPulse.
REQ-031 S_GAP:
- outDataEn=0 for exactly GAP_CYCLES cycles;
- then S_IDLE with Grant=00;
- Acks are 0.
REQ-032 LinkUp falling in S_HDR or S_XFER:
- Acks are 0 in that cycle;
- next cycle: AbortPulse=1, outDataEn=0, FSM in S_IDLE, Grant=00;
- S_GAP is skipped.
REQ-033 While LinkUp=0, no Ack, header or word SHALL be emitted.
REQ-034 Whenever outDataEn=0, outData SHALL equal IDLE_WORD.

Reset
REQ-035 On nRst low, asynchronously:
- FSM=S_IDLE;
- outData=IDLE_WORD, outDataEn=0, Grant=00;
- Acks, AbortPulse and TruncPulse=0;
- word and gap counters=0;
- round-robin pointer=status-first.
REQ-036 Reset mid-frame SHALL drop the frame with no AbortPulse; after release, operation restarts from S_IDLE.

Structure
REQ-037 A shared package bus_ctrl_pkg SHALL hold:
- the state enum;
- the defaults of HDR_DATA, HDR_STAT and IDLE_WORD;
- the Grant encodings.
REQ-038 The block SHALL have one sub-module, rr_arbiter2: a two-requester round-robin arbiter with a pointer register, updated only on grant.

Verification
REQ-039 LinkUp=1; data sends 3 words 0x001, 0x002, 0x003 (Last on 0x003) -> outDataEn run of 155,001,002,003, then 2 idle cycles, then Grant=00.
REQ-040 Both Reqs held high, 1-word frames -> headers alternate 2AA, 155, 2AA, 155.
REQ-041 DataReq low for 4 cycles mid-frame -> 4 cycles of outDataEn=0 with outData=0FA, then the stream resumes with no word lost or duplicated.
REQ-042 300-word frame with no Last -> 256 words emitted, TruncPulse on the 256th word's output cycle, remaining words start a new frame with a new header.
REQ-043 LinkUp dropped after the 2nd word -> AbortPulse one cycle later, no further output, Acks 0 until LinkUp returns.
REQ-044 nRst asserted mid-frame -> all outputs at reset values immediately, with no clock edge required.
